// File: rtl/alu_mc.sv
// ============================================================================
// Module      : alu_mc
// Description : RV32IM execute unit. Single-cycle base ALU ops plus iterative
//               shift-add multiply and restoring divide, with valid/ready flow.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_mc #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [4:0]      alu_control,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    localparam int SHAMT_W = $clog2(XLEN);

    localparam logic [4:0] OP_ADD    = 5'b00000;
    localparam logic [4:0] OP_SUB    = 5'b00001;
    localparam logic [4:0] OP_SLL    = 5'b00010;
    localparam logic [4:0] OP_SLT    = 5'b00011;
    localparam logic [4:0] OP_SLTU   = 5'b00100;
    localparam logic [4:0] OP_XOR    = 5'b00101;
    localparam logic [4:0] OP_SRL    = 5'b00110;
    localparam logic [4:0] OP_SRA    = 5'b00111;
    localparam logic [4:0] OP_OR     = 5'b01000;
    localparam logic [4:0] OP_AND    = 5'b01001;
    localparam logic [4:0] OP_MUL    = 5'b01010;
    localparam logic [4:0] OP_MULH   = 5'b01011;
    localparam logic [4:0] OP_MULHSU = 5'b01100;
    localparam logic [4:0] OP_MULHU  = 5'b01101;
    localparam logic [4:0] OP_DIV    = 5'b01110;
    localparam logic [4:0] OP_DIVU   = 5'b01111;
    localparam logic [4:0] OP_REM    = 5'b10000;
    localparam logic [4:0] OP_REMU   = 5'b10001;

    localparam logic [SHAMT_W-1:0] C_LAST_STEP = SHAMT_W'(XLEN - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [4:0]          op_q, op_d;
    logic [SHAMT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]     hi_q, hi_d;
    logic [XLEN-1:0]     lo_q, lo_d;
    logic [XLEN-1:0]     mcand_q, mcand_d;
    logic                neg_q, neg_d;
    logic                neg_r_q, neg_r_d;
    logic [XLEN-1:0]     result_q, result_d;

    logic                w_accept;
    logic                w_is_muldiv;
    logic                w_is_div_in;
    logic [SHAMT_W-1:0]  w_shamt;
    logic [XLEN-1:0]     w_sra;
    logic [XLEN-1:0]     w_base;
    logic                w_signed_a;
    logic                w_signed_b;
    logic                w_sign_a;
    logic                w_sign_b;
    logic [XLEN-1:0]     w_mag_a;
    logic [XLEN-1:0]     w_mag_b;
    logic [XLEN:0]       w_mul_sum;
    logic [XLEN:0]       w_div_r;
    logic                w_div_ge;
    logic                w_is_div_q;
    logic [XLEN-1:0]     w_step_hi;
    logic [XLEN-1:0]     w_step_lo;
    logic [2*XLEN-1:0]   w_prod;
    logic [2*XLEN-1:0]   w_prod_s;
    logic [XLEN-1:0]     w_quo;
    logic [XLEN-1:0]     w_rem;
    logic [XLEN-1:0]     w_final;

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign zero      = (result_q == '0);
    assign w_accept  = in_valid & in_ready;

    assign w_is_muldiv = (alu_control >= OP_MUL) && (alu_control <= OP_REMU);
    assign w_is_div_in = (alu_control >= OP_DIV);

    // Single-cycle base operations
    assign w_shamt = b[SHAMT_W-1:0];
    assign w_sra   = $signed(a) >>> w_shamt;

    always_comb begin
        w_base = '0;
        case (alu_control)
            OP_ADD:  w_base = a + b;
            OP_SUB:  w_base = a - b;
            OP_SLL:  w_base = a << w_shamt;
            OP_SLT:  w_base = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: w_base = {{(XLEN-1){1'b0}}, (a < b)};
            OP_XOR:  w_base = a ^ b;
            OP_SRL:  w_base = a >> w_shamt;
            OP_SRA:  w_base = w_sra;
            OP_OR:   w_base = a | b;
            OP_AND:  w_base = a & b;
            default: w_base = '0;
        endcase
    end

    // Iterative core works on magnitudes; signs are reapplied at the end
    assign w_signed_a = (alu_control == OP_MULH) || (alu_control == OP_MULHSU) ||
                        (alu_control == OP_DIV)  || (alu_control == OP_REM);
    assign w_signed_b = (alu_control == OP_MULH) || (alu_control == OP_DIV) ||
                        (alu_control == OP_REM);
    assign w_sign_a   = w_signed_a & a[XLEN-1];
    assign w_sign_b   = w_signed_b & b[XLEN-1];
    assign w_mag_a    = w_sign_a ? (~a + 1'b1) : a;
    assign w_mag_b    = w_sign_b ? (~b + 1'b1) : b;

    assign w_mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
    assign w_div_r    = {hi_q, lo_q[XLEN-1]};
    assign w_div_ge   = (w_div_r >= {1'b0, mcand_q});
    assign w_is_div_q = (op_q >= OP_DIV);

    // Remainder always stays below the divisor, so XLEN bits suffice
    assign w_step_hi = w_is_div_q ?
                       (w_div_ge ? (w_div_r[XLEN-1:0] - mcand_q) : w_div_r[XLEN-1:0]) :
                       w_mul_sum[XLEN:1];
    assign w_step_lo = w_is_div_q ? {lo_q[XLEN-2:0], w_div_ge} :
                                    {w_mul_sum[0], lo_q[XLEN-1:1]};

    assign w_prod   = {w_step_hi, w_step_lo};
    assign w_prod_s = neg_q ? (~w_prod + 1'b1) : w_prod;
    assign w_quo    = neg_q ? (~w_step_lo + 1'b1) : w_step_lo;
    assign w_rem    = neg_r_q ? (~w_step_hi + 1'b1) : w_step_hi;

    always_comb begin
        w_final = '0;
        case (op_q)
            OP_MUL:                        w_final = w_prod_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  w_final = w_prod_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:               w_final = w_quo;
            OP_REM, OP_REMU:               w_final = w_rem;
            default:                       w_final = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        mcand_d  = mcand_q;
        neg_d    = neg_q;
        neg_r_d  = neg_r_q;
        result_d = result_q;

        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_is_muldiv) begin
                        op_d    = alu_control;
                        cnt_d   = '0;
                        hi_d    = '0;
                        state_d = S_BUSY;
                        if (w_is_div_in) begin
                            lo_d    = w_mag_a;
                            mcand_d = w_mag_b;
                            // Divide by zero must yield all ones regardless of sign
                            neg_d   = (w_sign_a ^ w_sign_b) & (b != '0);
                            neg_r_d = w_sign_a;
                        end else begin
                            lo_d    = w_mag_b;
                            mcand_d = w_mag_a;
                            neg_d   = w_sign_a ^ w_sign_b;
                            neg_r_d = 1'b0;
                        end
                    end else begin
                        result_d = w_base;
                        state_d  = S_DONE;
                    end
                end
            end
            S_BUSY: begin
                hi_d  = w_step_hi;
                lo_d  = w_step_lo;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == C_LAST_STEP) begin
                    result_d = w_final;
                    cnt_d    = '0;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (flush) begin
            state_d  = S_IDLE;
            cnt_d    = '0;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            mcand_q  <= '0;
            neg_q    <= 1'b0;
            neg_r_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            mcand_q  <= mcand_d;
            neg_q    <= neg_d;
            neg_r_q  <= neg_r_d;
            result_q <= result_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_mc.sv
// ============================================================================
// Module      : tb_alu_mc
// Description : Directed vector bench for alu_mc (XLEN=32).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_mc;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  alu_control;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;

    int n_cmp  = 0;
    int n_fail = 0;

    alu_mc #(.XLEN(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .alu_control (alu_control),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .zero        (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    localparam int NV = 27;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [4:0] op, input logic [31:0] va, input logic [31:0] vb,
                          output logic [31:0] res, output logic z, output int lat);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        alu_control = op;
        a           = va;
        b           = vb;
        in_valid    = 1'b1;
        tick();
        in_valid = 1'b0;
        lat      = 1;
        while (!out_valid && lat < 200) begin
            tick();
            lat++;
        end
        res       = result;
        z         = zero;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] res;
        logic        z;
        int          lat;
        int          seen;

        vecs[0]  = '{"ADD",      5'h00, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1};
        vecs[1]  = '{"SUB",      5'h01, 32'h00000005, 32'h00000005, 32'h00000000, 1};
        vecs[2]  = '{"SLL",      5'h02, 32'h00000001, 32'h00000021, 32'h00000002, 1};
        vecs[3]  = '{"SLT",      5'h03, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1};
        vecs[4]  = '{"SLTU",     5'h04, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1};
        vecs[5]  = '{"XOR",      5'h05, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1};
        vecs[6]  = '{"SRL",      5'h06, 32'h80000000, 32'h00000004, 32'h08000000, 1};
        vecs[7]  = '{"SRA",      5'h07, 32'h80000000, 32'h00000024, 32'hF8000000, 1};
        vecs[8]  = '{"OR",       5'h08, 32'h00000F00, 32'h000000F0, 32'h00000FF0, 1};
        vecs[9]  = '{"AND",      5'h09, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1};
        vecs[10] = '{"ILLEGAL",  5'h1F, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1};
        vecs[11] = '{"MULHU",    5'h0D, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33};
        vecs[12] = '{"MUL",      5'h0A, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 33};
        vecs[13] = '{"MULHSU",   5'h0C, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 33};
        vecs[14] = '{"MULH_NEG", 5'h0B, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 33};
        vecs[15] = '{"MULH_POS", 5'h0B, 32'h40000000, 32'h00000004, 32'h00000001, 33};
        vecs[16] = '{"MUL_LO0",  5'h0A, 32'h40000000, 32'h00000004, 32'h00000000, 33};
        vecs[17] = '{"DIV",      5'h0E, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 33};
        vecs[18] = '{"REM",      5'h10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 33};
        vecs[19] = '{"DIVU_Z",   5'h0F, 32'h00000064, 32'h00000000, 32'hFFFFFFFF, 33};
        vecs[20] = '{"REMU_Z",   5'h11, 32'h00000009, 32'h00000000, 32'h00000009, 33};
        vecs[21] = '{"DIV_OVF",  5'h0E, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33};
        vecs[22] = '{"REM_OVF",  5'h10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 33};
        vecs[23] = '{"DIVU",     5'h0F, 32'h00000064, 32'h00000007, 32'h0000000E, 33};
        vecs[24] = '{"REMU",     5'h11, 32'h00000064, 32'h00000007, 32'h00000002, 33};
        vecs[25] = '{"DIV_NZ",   5'h0E, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFFF, 33};
        vecs[26] = '{"REM_NZ",   5'h10, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 33};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; alu_control = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        chk("reset_result",    result,           32'h0);
        chk("reset_zero",      {31'b0, zero},     32'h1);
        chk("reset_in_ready",  {31'b0, in_ready}, 32'h1);
        chk("reset_out_valid", {31'b0, out_valid}, 32'h0);

        for (int i = 0; i < NV; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, z, lat);
            chk({vecs[i].name, "_result"},  res,                  vecs[i].exp);
            chk({vecs[i].name, "_zero"},    {31'b0, z},           {31'b0, (vecs[i].exp == 32'h0)});
            chk({vecs[i].name, "_latency"}, 32'(lat),             32'(vecs[i].lat));
        end

        // Backpressure: result held for 5 cycles while consumer stalls
        alu_control = 5'h00; a = 32'd1; b = 32'd2; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        seen = 0;
        for (int k = 0; k < 5; k++) begin
            if (out_valid !== 1'b1 || result !== 32'd3 || in_ready !== 1'b0) seen++;
            tick();
        end
        chk("bp_stable_cycles_bad", 32'(seen), 32'h0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_in_ready_after",  {31'b0, in_ready},  32'h1);
        chk("bp_out_valid_after", {31'b0, out_valid}, 32'h0);

        // Flush at cycle 10 of a divide
        alu_control = 5'h0E; a = 32'd100; b = 32'd7; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_in_ready",  {31'b0, in_ready},  32'h1);
        chk("flush_out_valid", {31'b0, out_valid}, 32'h0);
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            if (out_valid) seen++;
            tick();
        end
        chk("flush_never_valid", 32'(seen), 32'h0);
        chk("flush_result_kept", result,    32'd3);

        // Flush wins over a simultaneous accept
        alu_control = 5'h00; a = 32'd1; b = 32'd1; in_valid = 1'b1; flush = 1'b1;
        tick();
        in_valid = 1'b0; flush = 1'b0;
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            if (out_valid || !in_ready) seen++;
            tick();
        end
        chk("flush_accept_dropped", 32'(seen), 32'h0);
        chk("flush_accept_result",  result,    32'd3);

        // Reset mid-BUSY
        alu_control = 5'h0E; a = 32'd100; b = 32'd7; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_busy_result",    result,            32'h0);
        chk("rst_busy_zero",      {31'b0, zero},     32'h1);
        chk("rst_busy_in_ready",  {31'b0, in_ready}, 32'h1);
        chk("rst_busy_out_valid", {31'b0, out_valid}, 32'h0);

        run_op(5'h00, 32'd2, 32'd3, res, z, lat);
        chk("post_rst_add", res, 32'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
